cpu: RTL and testbench

// - Minimal 8-bit sequencer/ALU CPU. Steps through an internal program ROM of {opcode, A, B} words and

---
 rtl/cpu_pkg.sv | 50 +++++
 rtl/cpu_alu.sv | 54 +++++
 rtl/cpu.sv | 127 ++++++++++++
 tb/tb_cpu.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit sequencer CPU.
// Covers opcodes, FSM state encoding, the instruction word layout and the built-in program image.
package cpu_pkg;

    localparam logic [7:0] OP_ADD  = 8'h00;
    localparam logic [7:0] OP_SUB  = 8'h01;
    localparam logic [7:0] OP_AND  = 8'h02;
    localparam logic [7:0] OP_OR   = 8'h03;
    localparam logic [7:0] OP_XOR  = 8'h04;
    localparam logic [7:0] OP_NOT  = 8'h05;
    localparam logic [7:0] OP_SHL  = 8'h06;
    localparam logic [7:0] OP_SHR  = 8'h07;
    localparam logic [7:0] OP_INC  = 8'h08;
    localparam logic [7:0] OP_DEC  = 8'h09;
    localparam logic [7:0] OP_CMP  = 8'h0A;
    localparam logic [7:0] OP_NOP  = 8'h80;
    localparam logic [7:0] OP_HALT = 8'hFF;

    localparam int unsigned MAX_DEPTH = 256;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_EXEC    = 2'd1,
        ST_PRESENT = 2'd2,
        ST_HALTED  = 2'd3
    } state_e;

    typedef struct packed {
        logic [7:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } instr_t;

    // Program image spans the full 8-bit address space; only the first DEPTH words are ever read.
    typedef instr_t [MAX_DEPTH-1:0] prog_t;

    function automatic prog_t builtin_prog();
        prog_t p;
        for (int i = 0; i < MAX_DEPTH; i++) p[i] = '{op: OP_NOP, a: 8'h00, b: 8'h00};
        p[0] = '{op: OP_ADD,  a: 8'h05, b: 8'h03};
        p[1] = '{op: OP_ADD,  a: 8'hF0, b: 8'h20};
        p[2] = '{op: OP_SUB,  a: 8'h03, b: 8'h05};
        p[3] = '{op: OP_AND,  a: 8'hCC, b: 8'hAA};
        p[4] = '{op: OP_HALT, a: 8'h00, b: 8'h00};
        return p;
    endfunction

    localparam prog_t BUILTIN_PROG = builtin_prog();

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: full 8-bit opcode decode to result, carry and borrow.
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [7:0] op_i,
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic [7:0] result_o,
    output logic       carry_o,
    output logic       borrow_o
);

    logic [8:0] sum;
    assign sum = {1'b0, a_i} + {1'b0, b_i};

    always_comb begin
        result_o = 8'h00;
        carry_o  = 1'b0;
        borrow_o = 1'b0;
        case (op_i)
            OP_ADD: begin
                result_o = sum[7:0];
                carry_o  = sum[8];
            end
            OP_SUB: begin
                result_o = a_i - b_i;
                borrow_o = (a_i < b_i);
            end
            OP_AND: result_o = a_i & b_i;
            OP_OR:  result_o = a_i | b_i;
            OP_XOR: result_o = a_i ^ b_i;
            OP_NOT: result_o = ~a_i;
            OP_SHL: begin
                result_o = {a_i[6:0], 1'b0};
                carry_o  = a_i[7];
            end
            OP_SHR: begin
                result_o = {1'b0, a_i[7:1]};
                carry_o  = a_i[0];
            end
            OP_INC: begin
                result_o = a_i + 8'd1;
                carry_o  = (a_i == 8'hFF);
            end
            OP_DEC: begin
                result_o = a_i - 8'd1;
                borrow_o = (a_i == 8'h00);
            end
            OP_CMP: borrow_o = (a_i < b_i);
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu.sv
// Minimal 8-bit sequencer CPU: fetch from program ROM, execute on cpu_alu, present to host.
// The host acknowledges each presented result with next_out before the PC advances.
module cpu
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter prog_t       INIT_PROG = BUILTIN_PROG
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       next_out,
    output logic       data_out,
    output logic [7:0] opcode,
    output logic [7:0] operand_A_out,
    output logic [7:0] operand_B_out,
    output logic [7:0] result_out_cpu,
    output logic       carry_out_cpu,
    output logic       borrow_out_cpu,
    output logic       result_ready,
    output logic [7:0] pc_out
);

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] op_q, op_d, a_q, a_d, b_q, b_d;
    logic [7:0] res_q, res_d;
    logic       c_q, c_d, bw_q, bw_d;
    logic       rdy_q, rdy_d, dv_q, dv_d;

    instr_t     rom_w;
    logic [7:0] alu_res;
    logic       alu_c, alu_bw;
    logic [7:0] pc_nxt;

    assign rom_w  = INIT_PROG[pc_q];
    assign pc_nxt = (pc_q == 8'(DEPTH - 1)) ? 8'h00 : pc_q + 8'd1;

    cpu_alu u_alu (
        .op_i     (op_q),
        .a_i      (a_q),
        .b_i      (b_q),
        .result_o (alu_res),
        .carry_o  (alu_c),
        .borrow_o (alu_bw)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        c_d     = c_q;
        bw_d    = bw_q;
        rdy_d   = 1'b0;
        dv_d    = dv_q;
        case (state_q)
            ST_FETCH: begin
                op_d    = rom_w.op;
                a_d     = rom_w.a;
                b_d     = rom_w.b;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                res_d   = alu_res;
                c_d     = alu_c;
                bw_d    = alu_bw;
                rdy_d   = 1'b1;
                state_d = ST_PRESENT;
            end
            ST_PRESENT: begin
                // First PRESENT cycle raises data_out; acks are honoured only once it is visible.
                if (!dv_q) begin
                    dv_d = 1'b1;
                end else if (next_out) begin
                    dv_d = 1'b0;
                    if (op_q == OP_HALT) begin
                        state_d = ST_HALTED;
                    end else begin
                        pc_d    = pc_nxt;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_HALTED: ;
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_FETCH;
            pc_q    <= 8'h00;
            op_q    <= 8'h00;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            res_q   <= 8'h00;
            c_q     <= 1'b0;
            bw_q    <= 1'b0;
            rdy_q   <= 1'b0;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            c_q     <= c_d;
            bw_q    <= bw_d;
            rdy_q   <= rdy_d;
            dv_q    <= dv_d;
        end
    end

    assign data_out       = dv_q;
    assign opcode         = op_q;
    assign operand_A_out  = a_q;
    assign operand_B_out  = b_q;
    assign result_out_cpu = res_q;
    assign carry_out_cpu  = c_q;
    assign borrow_out_cpu = bw_q;
    assign result_ready   = rdy_q;
    assign pc_out         = pc_q;

endmodule

// File: tb/tb_cpu.sv
// Directed bench for cpu: built-in program walk, HALT, mid-EXEC reset, ALU vectors, DEPTH=5 wrap.
module tb_cpu;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rst5 = 1'b0;
    logic next_out = 1'b0;
    always #5 clk = ~clk;

    logic       data_out, carry, borrow, rr;
    logic [7:0] opcode, opa, opb, res, pc;

    cpu dut (
        .clk(clk), .rst(rst), .next_out(next_out), .data_out(data_out),
        .opcode(opcode), .operand_A_out(opa), .operand_B_out(opb),
        .result_out_cpu(res), .carry_out_cpu(carry), .borrow_out_cpu(borrow),
        .result_ready(rr), .pc_out(pc)
    );

    function automatic prog_t prog_no_halt();
        prog_t p;
        p = BUILTIN_PROG;
        p[4] = '{op: OP_NOP, a: 8'h00, b: 8'h00};
        return p;
    endfunction
    localparam prog_t PROG5 = prog_no_halt();

    logic       dv5, c5, bw5, rr5;
    logic [7:0] op5, a5, b5, res5, pc5;

    cpu #(.DEPTH(5), .INIT_PROG(PROG5)) dut5 (
        .clk(clk), .rst(rst5), .next_out(1'b1), .data_out(dv5),
        .opcode(op5), .operand_A_out(a5), .operand_B_out(b5),
        .result_out_cpu(res5), .carry_out_cpu(c5), .borrow_out_cpu(bw5),
        .result_ready(rr5), .pc_out(pc5)
    );

    logic [7:0] alu_op, alu_a, alu_b, alu_r;
    logic       alu_c, alu_bw;

    cpu_alu u_alu (
        .op_i(alu_op), .a_i(alu_a), .b_i(alu_b),
        .result_o(alu_r), .carry_o(alu_c), .borrow_o(alu_bw)
    );

    int n_chk = 0;
    int n_err = 0;
    int rr_cnt = 0;

    always @(negedge clk) if (rr) rr_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Count rising edges until data_out is seen; bounded so a stuck DUT still reaches the summary.
    task automatic wait_present(input string tag, input int exp_edges);
        int  e;
        bit  seen;
        e = 0;
        seen = 1'b0;
        while (!seen && e < 12) begin
            @(posedge clk);
            e++;
            @(negedge clk);
            if (data_out) seen = 1'b1;
        end
        chk({tag, " data_out"}, 32'(seen), 32'd1);
        chk({tag, " latency"}, 32'(e), 32'(exp_edges));
    endtask

    task automatic ack();
        @(negedge clk) next_out = 1'b1;
        @(posedge clk);
        @(negedge clk) next_out = 1'b0;
    endtask

    task automatic chk_fields(input string tag, input logic [7:0] epc, input logic [7:0] eop,
                              input logic [7:0] ea, input logic [7:0] eb, input logic [7:0] eres,
                              input logic ec, input logic ebw);
        chk({tag, " pc"},     32'(pc),     32'(epc));
        chk({tag, " opcode"}, 32'(opcode), 32'(eop));
        chk({tag, " A"},      32'(opa),    32'(ea));
        chk({tag, " B"},      32'(opb),    32'(eb));
        chk({tag, " result"}, 32'(res),    32'(eres));
        chk({tag, " carry"},  32'(carry),  32'(ec));
        chk({tag, " borrow"}, 32'(borrow), 32'(ebw));
    endtask

    task automatic alu_vec(input string tag, input logic [7:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] er, input logic ec, input logic ebw);
        alu_op = op;
        alu_a  = a;
        alu_b  = b;
        #1;
        chk({tag, " res"}, 32'(alu_r),  32'(er));
        chk({tag, " c"},   32'(alu_c),  32'(ec));
        chk({tag, " b"},   32'(alu_bw), 32'(ebw));
    endtask

    initial begin
        logic [31:0] snap;
        int          changes;
        int          rr0;
        logic [7:0]  seq [6];
        int          nseq;
        bit          prev;
        int          cyc;

        repeat (3) @(negedge clk);
        chk("reset outputs", {data_out, opcode, opa, opb, res, carry, borrow, rr, pc}, 32'd0);

        rr0 = rr_cnt;
        rst = 1'b1;
        wait_present("pc0", 3);
        chk_fields("pc0", 8'h00, 8'h00, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0);
        snap = {opcode, opa, opb, res};
        changes = 0;
        repeat (20) begin
            @(negedge clk);
            if ({opcode, opa, opb, res} !== snap || !data_out || pc !== 8'h00) changes++;
        end
        chk("pc0 stable 20 cycles", 32'(changes), 32'd0);
        chk("pc0 result_ready pulses", 32'(rr_cnt - rr0), 32'd1);

        ack();
        wait_present("pc1", 3);
        chk_fields("pc1", 8'h01, 8'h00, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0);
        ack();
        wait_present("pc2", 3);
        chk_fields("pc2", 8'h02, 8'h01, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b1);
        ack();
        wait_present("pc3", 3);
        chk_fields("pc3", 8'h03, 8'h02, 8'hCC, 8'hAA, 8'h88, 1'b0, 1'b0);
        ack();
        wait_present("pc4", 3);
        chk("pc4 opcode", 32'(opcode), 32'hFF);

        ack();
        repeat (10) @(negedge clk);
        chk("halted data_out", 32'(data_out), 32'd0);
        chk("halted pc", 32'(pc), 32'd4);
        rr0 = rr_cnt;
        next_out = 1'b1;
        repeat (10) @(negedge clk);
        next_out = 1'b0;
        chk("halted ignores next_out", {data_out, pc, opcode, res}, {1'b0, 8'h04, 8'hFF, 8'h00});
        chk("halted no result_ready", 32'(rr_cnt - rr0), 32'd0);

        rst = 1'b0;
        @(negedge clk) rst = 1'b1;
        wait_present("rerun pc0", 3);
        ack();
        wait_present("rerun pc1", 3);
        ack();
        @(posedge clk);
        @(negedge clk);
        chk("exec of pc2 pc", 32'(pc), 32'd2);
        rst = 1'b0;
        #1;
        chk("async reset outputs", {data_out, opcode, opa, opb, res, carry, borrow, rr, pc}, 32'd0);
        @(negedge clk) rst = 1'b1;
        wait_present("after abort", 3);
        chk_fields("after abort", 8'h00, 8'h00, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0);

        alu_vec("SUB 00-01", 8'h01, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b1);
        alu_vec("INC FF",    8'h08, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0);
        alu_vec("SHR 01",    8'h07, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0);
        alu_vec("op 5A",     8'h5A, 8'h37, 8'h11, 8'h00, 1'b0, 1'b0);
        alu_vec("SHL 81",    8'h06, 8'h81, 8'h00, 8'h02, 1'b1, 1'b0);
        alu_vec("DEC 00",    8'h09, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b1);
        alu_vec("CMP 10<20", 8'h0A, 8'h10, 8'h20, 8'h00, 1'b0, 1'b1);

        @(negedge clk) rst5 = 1'b1;
        nseq = 0;
        prev = 1'b0;
        cyc  = 0;
        while (nseq < 6 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (dv5 && !prev) begin
                seq[nseq] = pc5;
                nseq++;
            end
            prev = dv5;
        end
        chk("depth5 presentations", 32'(nseq), 32'd6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("depth5 pc[%0d]", i), 32'(seq[i]), 32'(i % 5));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
